// File: rtl/aes_block_packer.sv
// Packs a valid/ready byte stream into 128-bit AES blocks (byte 0 in [127:120]), double-buffered.
// Latency: 16th byte at edge E0, block moves to out_reg at E1, data_in_stb high E2..E3 when aes_ready.
// Backpressure: byte_ready low while acc is full or a pad is pending; out_reg waits for aes_ready.
// Optional: define AES_PACKER_PKCS7_EN for PKCS#7 padding on flush (default is zero padding).
module aes_block_packer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             flush,
    input  logic             aes_ready,
    output logic [127:0]     data_in,
    output logic             data_in_stb,
    output logic             busy,
    output logic [CNT_W-1:0] blocks_sent
);
    logic [127:0] acc;
    logic [127:0] out_reg;
    logic [4:0]   cnt;
    logic         out_full;
    logic         pad_pend;

    logic         accept;
    logic         transfer;
    logic         issue;
    logic         pad_now;
    logic         pad_fill;
    logic [7:0]   pad_val;

    assign byte_ready = (cnt < 5'd16) && !pad_pend;
    assign accept     = byte_valid && byte_ready;
    // acc hands over to out_reg only once the previous block has been issued
    assign transfer   = (cnt == 5'd16) && !out_full;
    // Guarding on !data_in_stb keeps data_in stable for the whole strobe cycle
    assign issue      = out_full && aes_ready && !data_in_stb;
    // A pending pad resolves as soon as acc has room; a full acc waits for its transfer first
    assign pad_now    = pad_pend && (cnt < 5'd16);

`ifdef AES_PACKER_PKCS7_EN
    // PKCS#7: every pad byte carries the pad length; an empty acc becomes a full 0x10 block
    assign pad_val  = 8'(5'd16 - cnt);
    assign pad_fill = pad_now;
`else
    // Zero padding: an empty acc just drops the request, no extra block is produced
    assign pad_val  = 8'h00;
    assign pad_fill = pad_now && (cnt != 5'd0);
`endif

    assign data_in = out_reg;
    assign busy    = (cnt != 5'd0) || out_full || pad_pend;

    // Assembly register: collect bytes MSB-first, pad the tail, clear on hand-over
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (transfer) begin
            acc <= '0;
            cnt <= '0;
        end else if (pad_fill) begin
            for (int i = 0; i < 16; i++) begin
                if (5'(i) >= cnt) begin
                    acc[127-8*i -: 8] <= pad_val;
                end
            end
            cnt <= 5'd16;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) begin
                if (5'(i) == cnt) begin
                    acc[127-8*i -: 8] <= byte_in;
                end
            end
            cnt <= cnt + 5'd1;
        end
    end

    // Flush latch: a byte accepted alongside flush lands first, so the pad covers cnt+1 onward
    always_ff @(posedge clk) begin
        if (reset) begin
            pad_pend <= 1'b0;
        end else if (pad_now) begin
            pad_pend <= 1'b0;
        end else if (flush) begin
            pad_pend <= 1'b1;
        end
    end

    // Output buffer: hold the finished block until the core is ready, then strobe it once
    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg     <= '0;
            out_full    <= 1'b0;
            data_in_stb <= 1'b0;
            blocks_sent <= '0;
        end else begin
            data_in_stb <= issue;
            if (transfer) begin
                out_reg  <= acc;
                out_full <= 1'b1;
            end else if (issue) begin
                out_full <= 1'b0;
            end
            if (issue) begin
                blocks_sent <= blocks_sent + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: vector table, timing sequences, random run vs queue model.
// A second instance with a 4-bit counter exercises blocks_sent wrap-around.
// Expected blocks come from a byte-queue model of the padding rules, not from the DUT.
module tb_aes_block_packer;
`ifdef AES_PACKER_PKCS7_EN
    localparam bit PKCS7 = 1'b1;
`else
    localparam bit PKCS7 = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic         flush;
    logic         aes_ready;
    logic [127:0] data_in;
    logic         data_in_stb;
    logic         busy;
    logic [15:0]  blocks_sent;

    logic         byte_ready_w;
    logic [127:0] data_in_w;
    logic         data_in_stb_w;
    logic         busy_w;
    logic [3:0]   blocks_sent_w;

    aes_block_packer dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .flush(flush), .aes_ready(aes_ready),
        .data_in(data_in), .data_in_stb(data_in_stb), .busy(busy), .blocks_sent(blocks_sent)
    );

    aes_block_packer #(.CNT_W(4)) dut_w (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready_w), .flush(flush), .aes_ready(aes_ready),
        .data_in(data_in_w), .data_in_stb(data_in_stb_w), .busy(busy_w), .blocks_sent(blocks_sent_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int strobes = 0;
    int made = 0;
    logic [127:0] last_blk = '0;
    logic [7:0]   pend[$];
    logic [127:0] expq[$];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference model: flush appends pad bytes to the pending byte list
    function automatic void model_flush();
        int l;
        int p;
        l = pend.size();
        p = 16 - l;
        if (PKCS7) begin
            for (int i = 0; i < p; i++) pend.push_back(8'(p));
        end else if (l != 0) begin
            for (int i = 0; i < p; i++) pend.push_back(8'h00);
        end
    endfunction

    // Monitor: track accepted bytes/flushes, form expected blocks, score every strobe
    always @(negedge clk) begin
        if (reset) begin
            pend.delete();
            expq.delete();
        end else begin
            if (byte_valid && byte_ready) pend.push_back(byte_in);
            if (flush) model_flush();
            while (pend.size() >= 16) begin
                logic [127:0] b;
                b = '0;
                for (int i = 0; i < 16; i++) b = {b[119:0], pend.pop_front()};
                expq.push_back(b);
                made++;
            end
        end
        if (data_in_stb) begin
            strobes++;
            last_blk = data_in;
            if (expq.size() == 0) begin
                timeout("unexpected_strobe");
            end else begin
                chk("strobe_data", data_in, expq.pop_front());
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        byte_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        strobes = 0;
        made = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fl);
        int n;
        bit done;
        n = 0;
        done = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (!done) begin
            flush = fl && byte_ready;
            @(negedge clk);
            if (byte_ready) begin
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                n++;
                if (n > 500) begin
                    timeout("send_byte");
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || data_in_stb) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy || data_in_stb) timeout("wait_idle");
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]   first;
        logic [7:0]   step;
        int           n;
        bit           fl_after;
        bit           fl_last;
        int           exp_n;
        logic [127:0] exp_last;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int acc_n;
        int c;
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n;
        int c;
        tbl[0] = '{8'h00, 8'h01, 16, 1'b0, 1'b0, 1, 128'h000102030405060708090A0B0C0D0E0F};
        tbl[1] = '{8'hAA, 8'h11, 3, 1'b1, 1'b0, 1,
                   PKCS7 ? {24'hAABBCC, {13{8'h0D}}} : {24'hAABBCC, 104'h0}};
        tbl[2] = '{8'h11, 8'h00, 16, 1'b1, 1'b0, PKCS7 ? 2 : 1,
                   PKCS7 ? {16{8'h10}} : {16{8'h11}}};
        tbl[3] = '{8'h00, 8'h00, 0, 1'b1, 1'b0, PKCS7 ? 1 : 0, {16{8'h10}}};
        tbl[4] = '{8'h40, 8'h01, 20, 1'b1, 1'b0, 2,
                   PKCS7 ? {32'h50515253, {12{8'h0C}}} : {32'h50515253, 96'h0}};
        tbl[5] = '{8'h60, 8'h01, 15, 1'b0, 1'b1, 1,
                   {120'h606162636465666768696A6B6C6D6E, PKCS7 ? 8'h01 : 8'h00}};
        tbl[6] = '{8'h70, 8'h01, 16, 1'b0, 1'b1, PKCS7 ? 2 : 1,
                   PKCS7 ? {16{8'h10}} : 128'h707172737475767778797A7B7C7D7E7F};

        reset = 1'b1;
        byte_in = '0;
        byte_valid = 1'b0;
        flush = 1'b0;
        aes_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_byte_ready", 128'(byte_ready), 128'd1);
        chk("rst_data_in", data_in, 128'd0);
        chk("rst_stb", 128'(data_in_stb), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_blocks_sent", 128'(blocks_sent), 128'd0);
        @(posedge clk);
        #1;

        // Latency of a single block: strobe two edges after the 16th byte
        for (int k = 0; k < 16; k++) send_byte(8'(k), 1'b0);
        @(negedge clk);
        chk("lat_e0_stb", 128'(data_in_stb), 128'd0);
        chk("lat_e0_ready", 128'(byte_ready), 128'd0);
        @(negedge clk);
        chk("lat_e1_stb", 128'(data_in_stb), 128'd0);
        chk("lat_e1_ready", 128'(byte_ready), 128'd1);
        @(negedge clk);
        chk("lat_e2_stb", 128'(data_in_stb), 128'd1);
        chk("lat_e2_data", data_in, 128'h000102030405060708090A0B0C0D0E0F);
        @(negedge clk);
        chk("lat_e3_stb", 128'(data_in_stb), 128'd0);
        chk("lat_blocks_sent", 128'(blocks_sent), 128'd1);
        @(posedge clk);
        #1;

        // Vector table
        for (int t = 0; t < 7; t++) begin
            do_reset();
            aes_ready = 1'b1;
            for (int k = 0; k < tbl[t].n; k++)
                send_byte(8'(tbl[t].first + 8'(k) * tbl[t].step), tbl[t].fl_last && (k == tbl[t].n - 1));
            if (tbl[t].fl_after) pulse_flush();
            wait_idle();
            chk($sformatf("vec%0d_strobes", t), 128'(strobes), 128'(tbl[t].exp_n));
            if (tbl[t].exp_n > 0) chk($sformatf("vec%0d_last", t), last_blk, tbl[t].exp_last);
            chk($sformatf("vec%0d_blocks_sent", t), 128'(blocks_sent), 128'(tbl[t].exp_n));
            chk($sformatf("vec%0d_model_drained", t), 128'(expq.size()), 128'd0);
        end

        // Backpressure: 32 bytes held, nothing issued while the core is not ready
        do_reset();
        aes_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 60; i++) begin
            byte_valid = (acc_n < 40);
            byte_in = 8'h80 + 8'(acc_n);
            @(negedge clk);
            if (byte_valid && byte_ready) acc_n++;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 128'(acc_n), 128'd32);
        chk("bp_no_strobe", 128'(strobes), 128'd0);
        chk("bp_ready_low", 128'(byte_ready), 128'd0);
        aes_ready = 1'b1;
        c = 0;
        while (acc_n < 40 && c < 100) begin
            byte_valid = 1'b1;
            byte_in = 8'h80 + 8'(acc_n);
            @(negedge clk);
            if (byte_valid && byte_ready) acc_n++;
            @(posedge clk);
            #1;
            c++;
        end
        byte_valid = 1'b0;
        chk("bp_accepted_all", 128'(acc_n), 128'd40);
        chk("bp_strobes", 128'(strobes), 128'd2);
        chk("bp_blocks_sent", 128'(blocks_sent), 128'd2);

        // Reset mid-block discards the partial block
        do_reset();
        for (int k = 0; k < 7; k++) send_byte(8'hE0 + 8'(k), 1'b0);
        do_reset();
        for (int k = 0; k < 16; k++) send_byte(8'h20 + 8'(k), 1'b0);
        wait_idle();
        chk("rstmid_strobes", 128'(strobes), 128'd1);
        chk("rstmid_data", last_blk, 128'h202122232425262728292A2B2C2D2E2F);
        chk("rstmid_blocks_sent", 128'(blocks_sent), 128'd1);

        // Counter wrap on the 4-bit instance after 17 blocks
        do_reset();
        for (int k = 0; k < 17 * 16; k++) send_byte(8'(k * 7), 1'b0);
        wait_idle();
        chk("wrap_blocks_sent_w", 128'(blocks_sent_w), 128'(17 % 16));
        chk("wrap_blocks_sent", 128'(blocks_sent), 128'd17);

        // Randomized traffic against the queue model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            byte_valid = ($urandom_range(0, 9) < 7);
            byte_in = 8'($urandom);
            aes_ready = ($urandom_range(0, 9) < 6);
            flush = byte_ready && ($urandom_range(0, 24) == 0);
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        flush = 1'b0;
        aes_ready = 1'b1;
        c = 0;
        while (!byte_ready && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (!byte_ready) timeout("rand_ready");
        pulse_flush();
        wait_idle();
        chk("rand_model_drained", 128'(expq.size()), 128'd0);
        chk("rand_pending_empty", 128'(pend.size()), 128'd0);
        chk("rand_strobes", 128'(strobes), 128'(made));
        chk("rand_blocks_sent", 128'(blocks_sent), 128'(16'(made)));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
